// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector engine and the card controller:
// default geometry, timeout and the state encoding.
package sd_pkg;

  localparam int SD_SECTOR_BYTES = 512;
  localparam int SD_ADDR_W       = 12;
  localparam int SD_TIMEOUT      = 255;

  typedef logic [2:0] sd_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/sd_sector_engine_if.sv
// Host command/stream, card byte port and status signals of the sector engine.
interface sd_sector_engine_if
  import sd_pkg::*;
#(
  parameter int ADDR_W       = SD_ADDR_W,
  parameter int SECTOR_BYTES = SD_SECTOR_BYTES
);

  localparam int SECTOR_W = ADDR_W - $clog2(SECTOR_BYTES);

  logic                i_cmd_valid;
  logic                i_cmd_write;
  logic [SECTOR_W-1:0] i_cmd_sector;
  logic                o_cmd_ready;
  logic                i_abort;

  logic [7:0]          i_wr_data;
  logic                i_wr_valid;
  logic                o_wr_ready;

  logic [7:0]          o_rd_data;
  logic                o_rd_valid;
  logic                i_rd_ready;

  logic [7:0]          o_sd_data;
  logic [ADDR_W-1:0]   o_sd_address;
  logic                o_sd_write;
  logic                o_sd_request;
  logic [7:0]          i_sd_data;
  logic                i_sd_data_DV;

  logic                o_busy;
  logic                o_done;
  logic                o_error;

  modport master (
    output i_cmd_valid, i_cmd_write, i_cmd_sector, i_abort,
    output i_wr_data, i_wr_valid, i_rd_ready, i_sd_data, i_sd_data_DV,
    input  o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid,
    input  o_sd_data, o_sd_address, o_sd_write, o_sd_request,
    input  o_busy, o_done, o_error
  );

  modport slave (
    input  i_cmd_valid, i_cmd_write, i_cmd_sector, i_abort,
    input  i_wr_data, i_wr_valid, i_rd_ready, i_sd_data, i_sd_data_DV,
    output o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid,
    output o_sd_data, o_sd_address, o_sd_write, o_sd_request,
    output o_busy, o_done, o_error
  );

endinterface

// File: rtl/sd_timeout_counter.sv
// Counts enabled cycles since the last clear; expired marks the LIMIT-th
// enabled cycle so the caller can act on it within that same cycle.
module sd_timeout_counter
  import sd_pkg::*;
#(
  parameter int LIMIT = SD_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/sd_sector_engine.sv
// Moves one sector between the host byte streams and the card byte port,
// one request per byte, with a per-byte completion timeout and abort.
module sd_sector_engine
  import sd_pkg::*;
#(
  parameter int SECTOR_BYTES = SD_SECTOR_BYTES,
  parameter int ADDR_W       = SD_ADDR_W,
  parameter int TIMEOUT      = SD_TIMEOUT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  sd_sector_engine_if.slave   bus
);

  localparam int BYTE_W = $clog2(SECTOR_BYTES);

  sd_state_t         state;
  logic [BYTE_W-1:0] count;
  logic [ADDR_W-1:0] base_addr;

  logic [BYTE_W-1:0] count_next;
  logic [ADDR_W-1:0] accept_base;
  logic              last_byte;
  logic              timer_expired;

  assign count_next  = count + 1'b1;
  assign last_byte   = (count == BYTE_W'(SECTOR_BYTES - 1));
  // Sector size is a power of two, so the base is the sector index shifted up.
  assign accept_base = {bus.i_cmd_sector, {BYTE_W{1'b0}}};

  sd_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clear   (state == ST_ISSUE),
    .enable  (state == ST_WAIT),
    .expired (timer_expired)
  );

  // Outputs are set on the transition into the state they belong to, so every
  // strobe is registered and lines up with the state it describes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= ST_IDLE;
      count            <= '0;
      base_addr        <= '0;
      bus.o_cmd_ready  <= 1'b1;
      bus.o_wr_ready   <= 1'b0;
      bus.o_rd_data    <= '0;
      bus.o_rd_valid   <= 1'b0;
      bus.o_sd_data    <= '0;
      bus.o_sd_address <= '0;
      bus.o_sd_write   <= 1'b0;
      bus.o_sd_request <= 1'b0;
      bus.o_busy       <= 1'b0;
      bus.o_done       <= 1'b0;
      bus.o_error      <= 1'b0;
    end else begin
      bus.o_done <= 1'b0;
      if (bus.i_abort && state != ST_IDLE) begin
        state            <= ST_IDLE;
        bus.o_cmd_ready  <= 1'b1;
        bus.o_busy       <= 1'b0;
        bus.o_wr_ready   <= 1'b0;
        bus.o_rd_valid   <= 1'b0;
        bus.o_sd_request <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.i_cmd_valid && bus.o_cmd_ready) begin
              base_addr       <= accept_base;
              count           <= '0;
              bus.o_error     <= 1'b0;
              bus.o_busy      <= 1'b1;
              bus.o_cmd_ready <= 1'b0;
              bus.o_sd_write  <= bus.i_cmd_write;
              if (bus.i_cmd_write) begin
                state          <= ST_FETCH;
                bus.o_wr_ready <= 1'b1;
              end else begin
                state            <= ST_ISSUE;
                bus.o_sd_request <= 1'b1;
                bus.o_sd_address <= accept_base;
              end
            end
          end

          ST_FETCH: begin
            if (bus.i_wr_valid) begin
              bus.o_sd_data    <= bus.i_wr_data;
              bus.o_wr_ready   <= 1'b0;
              bus.o_sd_request <= 1'b1;
              bus.o_sd_address <= base_addr + ADDR_W'(count);
              state            <= ST_ISSUE;
            end
          end

          ST_ISSUE: begin
            bus.o_sd_request <= 1'b0;
            state            <= ST_WAIT;
          end

          ST_WAIT: begin
            if (bus.i_sd_data_DV) begin
              if (!bus.o_sd_write) begin
                bus.o_rd_data  <= bus.i_sd_data;
                bus.o_rd_valid <= 1'b1;
                state          <= ST_HOLD;
              end else if (last_byte) begin
                bus.o_done <= 1'b1;
                bus.o_busy <= 1'b0;
                state      <= ST_DONE;
              end else begin
                count          <= count_next;
                bus.o_wr_ready <= 1'b1;
                state          <= ST_FETCH;
              end
            end else if (timer_expired) begin
              bus.o_error     <= 1'b1;
              bus.o_busy      <= 1'b0;
              bus.o_cmd_ready <= 1'b1;
              state           <= ST_IDLE;
            end
          end

          ST_HOLD: begin
            if (bus.i_rd_ready) begin
              bus.o_rd_valid <= 1'b0;
              if (last_byte) begin
                bus.o_done <= 1'b1;
                bus.o_busy <= 1'b0;
                state      <= ST_DONE;
              end else begin
                count            <= count_next;
                bus.o_sd_request <= 1'b1;
                bus.o_sd_address <= base_addr + ADDR_W'(count_next);
                state            <= ST_ISSUE;
              end
            end
          end

          ST_DONE: begin
            bus.o_cmd_ready <= 1'b1;
            state           <= ST_IDLE;
          end

          default: begin
            bus.o_cmd_ready <= 1'b1;
            bus.o_busy      <= 1'b0;
            state           <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_sector_engine.sv
// Directed bench for sd_sector_engine with a behavioural card model that
// answers each request one cycle later (optionally delayed or withheld).
module tb_sd_sector_engine;

  logic i_clk;
  logic i_rst_n;

  sd_sector_engine_if #(.ADDR_W(12), .SECTOR_BYTES(512)) bus ();

  sd_sector_engine #(
    .SECTOR_BYTES (512),
    .ADDR_W       (12),
    .TIMEOUT      (255)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem    [0:4095];
  logic [7:0] golden [0:4095];

  // Card model and statistics
  bit         card_enable = 1'b1;
  int         card_delay  = 0;
  bit         pend        = 1'b0;
  int         pend_wait   = 0;
  bit         pend_write  = 1'b0;
  logic [11:0] pend_addr  = '0;
  logic [7:0] pend_wdata  = '0;
  int         req_count   = 0;
  int         write_reqs  = 0;
  int         seq_err     = 0;
  int         done_count  = 0;
  logic [11:0] first_addr = '0;
  logic [11:0] last_addr  = '0;

  always @(negedge i_clk) begin
    bus.i_sd_data_DV = 1'b0;
    if (!i_rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (pend_wait > 0) begin
          pend_wait--;
        end else begin
          bus.i_sd_data_DV = 1'b1;
          if (pend_write) mem[pend_addr] = pend_wdata;
          else bus.i_sd_data = mem[pend_addr];
          pend = 1'b0;
        end
      end
      if (bus.o_sd_request) begin
        if (req_count == 0) first_addr = bus.o_sd_address;
        else if (bus.o_sd_address != last_addr + 12'd1) seq_err++;
        last_addr = bus.o_sd_address;
        req_count++;
        if (bus.o_sd_write) write_reqs++;
        if (card_enable) begin
          pend       = 1'b1;
          pend_wait  = card_delay;
          pend_write = bus.o_sd_write;
          pend_addr  = bus.o_sd_address;
          pend_wdata = bus.o_sd_data;
        end
      end
    end
  end

  always @(negedge i_clk) if (bus.o_done === 1'b1) done_count++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_stats();
    req_count  = 0;
    write_reqs = 0;
    seq_err    = 0;
    done_count = 0;
    first_addr = '0;
    last_addr  = '0;
  endtask

  task automatic issue_cmd(input logic wr, input logic [2:0] sector);
    bus.i_cmd_valid  = 1'b1;
    bus.i_cmd_write  = wr;
    bus.i_cmd_sector = sector;
    @(negedge i_clk);
    bus.i_cmd_valid  = 1'b0;
  endtask

  task automatic run_write(input logic [2:0] sector, output bit timed_out);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    timed_out = 1'b1;
    issue_cmd(1'b1, sector);
    while (cyc < 20000) begin
      if (bus.o_done) begin
        timed_out = 1'b0;
        break;
      end
      if (bus.o_wr_ready) begin
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = idx[7:0];
        idx++;
      end else begin
        bus.i_wr_valid = 1'b0;
      end
      @(negedge i_clk);
      cyc++;
    end
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic run_read(input logic [2:0] sector, input int stall, input int abort_at,
                          input int poke_at, output int bytes, output int data_err,
                          output int stable_err, output bit timed_out);
    int hold;
    int cyc;
    int base;
    bit abort_next;
    bit poked;
    logic [7:0] captured;
    bytes = 0; data_err = 0; stable_err = 0; timed_out = 1'b1;
    hold = 0; cyc = 0; abort_next = 1'b0; poked = 1'b0; captured = '0;
    base = int'(sector) * 512;
    issue_cmd(1'b0, sector);
    while (cyc < 20000) begin
      bus.i_cmd_valid = 1'b0;
      if (abort_next) begin
        bus.i_abort = 1'b1;
        @(negedge i_clk);
        bus.i_abort = 1'b0;
        timed_out = 1'b0;
        break;
      end
      if (bus.o_done) begin
        timed_out = 1'b0;
        break;
      end
      if (bus.o_sd_request && bytes == abort_at) abort_next = 1'b1;
      if (!poked && poke_at >= 0 && bytes == poke_at) begin
        bus.i_cmd_valid  = 1'b1;
        bus.i_cmd_write  = 1'b1;
        bus.i_cmd_sector = 3'd0;
        poked = 1'b1;
      end
      if (bus.o_rd_valid) begin
        if (hold == 0) captured = bus.o_rd_data;
        else if (bus.o_rd_data !== captured) stable_err++;
        if (hold >= stall) begin
          bus.i_rd_ready = 1'b1;
          if (bus.o_rd_data !== golden[base + bytes]) data_err++;
          bytes++;
          hold = 0;
        end else begin
          bus.i_rd_ready = 1'b0;
          hold++;
        end
      end else begin
        bus.i_rd_ready = 1'b0;
        hold = 0;
      end
      @(negedge i_clk);
      cyc++;
    end
    bus.i_rd_ready  = 1'b0;
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    checks++; if (bus.o_cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", bus.o_cmd_ready); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.o_busy); end
    checks++; if ({bus.o_done, bus.o_error, bus.o_rd_valid, bus.o_wr_ready, bus.o_sd_request} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_strobes: got %b expected 00000", {bus.o_done, bus.o_error, bus.o_rd_valid, bus.o_wr_ready, bus.o_sd_request}); end
    checks++; if (bus.o_sd_address !== 12'h000) begin errors++; $display("[TB] FAIL reset_address: got %h expected 000", bus.o_sd_address); end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    bus.i_abort = 1'b1;
    @(negedge i_clk);
    bus.i_abort = 1'b0;
    checks++; if (bus.o_cmd_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_abort: got ready=%b busy=%b expected ready=1 busy=0", bus.o_cmd_ready, bus.o_busy); end
  endtask

  task automatic test_write_sector();
    bit to;
    int wr_err;
    clear_stats();
    run_write(3'd2, to);
    repeat (2) @(negedge i_clk);
    wr_err = 0;
    for (int i = 0; i < 512; i++) begin
      if (mem[12'h400 + i] !== 8'(i)) wr_err++;
      golden[12'h400 + i] = 8'(i);
    end
    checks++; if (to) begin errors++; $display("[TB] FAIL write_timeout: got no o_done expected o_done within budget"); end
    checks++; if (req_count != 512 || write_reqs != 512) begin errors++; $display("[TB] FAIL write_requests: got %0d/%0d expected 512/512", req_count, write_reqs); end
    checks++; if (first_addr !== 12'h400 || last_addr !== 12'h5FF) begin errors++; $display("[TB] FAIL write_addr_range: got %h..%h expected 400..5ff", first_addr, last_addr); end
    checks++; if (seq_err != 0) begin errors++; $display("[TB] FAIL write_addr_seq: got %0d gaps expected 0", seq_err); end
    checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL write_done: got %0d pulses expected 1", done_count); end
    checks++; if (wr_err != 0) begin errors++; $display("[TB] FAIL write_data: got %0d bad bytes expected 0", wr_err); end
    checks++; if (bus.o_busy !== 1'b0 || bus.o_cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL write_idle: got busy=%b ready=%b expected 0/1", bus.o_busy, bus.o_cmd_ready); end
  endtask

  task automatic test_readback_ignore_cmd();
    bit to; int bytes; int derr; int serr;
    clear_stats();
    run_read(3'd2, 0, -1, 5, bytes, derr, serr, to);
    repeat (2) @(negedge i_clk);
    checks++; if (to || bytes != 512) begin errors++; $display("[TB] FAIL readback_bytes: got %0d expected 512", bytes); end
    checks++; if (derr != 0) begin errors++; $display("[TB] FAIL readback_data: got %0d bad bytes expected 0", derr); end
    checks++; if (req_count != 512 || write_reqs != 0 || seq_err != 0) begin
      errors++; $display("[TB] FAIL readback_requests: got req=%0d wr=%0d gaps=%0d expected 512/0/0", req_count, write_reqs, seq_err); end
    checks++; if (first_addr !== 12'h400 || last_addr !== 12'h5FF) begin errors++; $display("[TB] FAIL readback_addr: got %h..%h expected 400..5ff", first_addr, last_addr); end
    checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL readback_done: got %0d expected 1", done_count); end
  endtask

  task automatic test_read_stall();
    bit to; int bytes; int derr; int serr;
    clear_stats();
    run_read(3'd7, 3, -1, -1, bytes, derr, serr, to);
    repeat (2) @(negedge i_clk);
    checks++; if (to || bytes != 512) begin errors++; $display("[TB] FAIL stall_bytes: got %0d expected 512", bytes); end
    checks++; if (derr != 0) begin errors++; $display("[TB] FAIL stall_data: got %0d bad bytes expected 0", derr); end
    checks++; if (serr != 0) begin errors++; $display("[TB] FAIL stall_hold_stable: got %0d changes expected 0", serr); end
    checks++; if (req_count != 512 || last_addr !== 12'hFFF || first_addr !== 12'hE00) begin
      errors++; $display("[TB] FAIL stall_requests: got req=%0d %h..%h expected 512 e00..fff", req_count, first_addr, last_addr); end
    checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL stall_done: got %0d expected 1", done_count); end
  endtask

  task automatic test_read_latency();
    clear_stats();
    issue_cmd(1'b0, 3'd5);
    checks++; if (bus.o_sd_request !== 1'b1 || bus.o_sd_address !== 12'hA00 || bus.o_sd_write !== 1'b0) begin
      errors++; $display("[TB] FAIL latency_request: got req=%b addr=%h wr=%b expected 1/a00/0", bus.o_sd_request, bus.o_sd_address, bus.o_sd_write); end
    checks++; if (bus.o_busy !== 1'b1 || bus.o_cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL latency_busy: got busy=%b ready=%b expected 1/0", bus.o_busy, bus.o_cmd_ready); end
    @(negedge i_clk);
    checks++; if (bus.o_sd_request !== 1'b0 || bus.o_rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_wait: got req=%b valid=%b expected 0/0", bus.o_sd_request, bus.o_rd_valid); end
    @(negedge i_clk);
    checks++; if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== golden[12'hA00]) begin
      errors++; $display("[TB] FAIL latency_rd_valid: got valid=%b data=%h expected 1/%h", bus.o_rd_valid, bus.o_rd_data, golden[12'hA00]); end
    bus.i_abort = 1'b1;
    @(negedge i_clk);
    bus.i_abort = 1'b0;
    checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_abort: got valid=%b busy=%b ready=%b expected 0/0/1", bus.o_rd_valid, bus.o_busy, bus.o_cmd_ready); end
    @(negedge i_clk);
    checks++; if (done_count != 0) begin errors++; $display("[TB] FAIL hold_abort_done: got %0d expected 0", done_count); end
  endtask

  task automatic test_timeout();
    clear_stats();
    card_enable = 1'b0;
    issue_cmd(1'b0, 3'd1);
    repeat (255) @(negedge i_clk);
    checks++; if (bus.o_error !== 1'b0 || bus.o_busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_early: got err=%b busy=%b expected 0/1", bus.o_error, bus.o_busy); end
    @(negedge i_clk);
    checks++; if (bus.o_error !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_flag: got err=%b busy=%b ready=%b expected 1/0/1", bus.o_error, bus.o_busy, bus.o_cmd_ready); end
    @(negedge i_clk);
    checks++; if (done_count != 0 || bus.o_error !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got done=%0d err=%b expected 0/1", done_count, bus.o_error); end
    card_enable = 1'b1;
    issue_cmd(1'b0, 3'd3);
    checks++; if (bus.o_error !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear: got err=%b expected 0", bus.o_error); end
    bus.i_abort = 1'b1;
    @(negedge i_clk);
    bus.i_abort = 1'b0;
    @(negedge i_clk);
    checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_cmd_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL late_dv_ignored: got valid=%b ready=%b busy=%b expected 0/1/0", bus.o_rd_valid, bus.o_cmd_ready, bus.o_busy); end
  endtask

  task automatic test_abort_wait();
    bit to; int bytes; int derr; int serr;
    clear_stats();
    card_delay = 1;
    run_read(3'd4, 0, 10, -1, bytes, derr, serr, to);
    checks++; if (to || bytes != 10 || derr != 0) begin errors++; $display("[TB] FAIL abort_progress: got bytes=%0d bad=%0d expected 10/0", bytes, derr); end
    checks++; if (bus.o_busy !== 1'b0 || bus.o_cmd_ready !== 1'b1 || bus.o_rd_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_idle: got busy=%b ready=%b valid=%b expected 0/1/0", bus.o_busy, bus.o_cmd_ready, bus.o_rd_valid); end
    @(negedge i_clk);
    checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_cmd_ready !== 1'b1 || done_count != 0) begin
      errors++; $display("[TB] FAIL abort_dv_ignored: got valid=%b ready=%b done=%0d expected 0/1/0", bus.o_rd_valid, bus.o_cmd_ready, done_count); end
    card_delay = 0;
    @(negedge i_clk);
  endtask

  task automatic test_reset_in_hold();
    bit to; bit found; int bytes; int derr; int serr;
    clear_stats();
    issue_cmd(1'b0, 3'd6);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.o_rd_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL reset_hold_reach: got no o_rd_valid expected HOLD within 20 cycles"); end
    i_rst_n = 1'b0;
    #1;
    checks++; if (bus.o_rd_valid !== 1'b0 || bus.o_cmd_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_async: got valid=%b ready=%b busy=%b expected 0/1/0", bus.o_rd_valid, bus.o_cmd_ready, bus.o_busy); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    clear_stats();
    run_read(3'd0, 0, -1, -1, bytes, derr, serr, to);
    repeat (2) @(negedge i_clk);
    checks++; if (to || bytes != 512 || derr != 0) begin errors++; $display("[TB] FAIL after_reset_read: got bytes=%0d bad=%0d expected 512/0", bytes, derr); end
    checks++; if (req_count != 512 || first_addr !== 12'h000 || last_addr !== 12'h1FF || done_count != 1) begin
      errors++; $display("[TB] FAIL after_reset_requests: got req=%0d %h..%h done=%0d expected 512 000..1ff 1", req_count, first_addr, last_addr, done_count); end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      golden[a] = 8'((a * 37) + (a >> 8) + 5);
      mem[a]    = golden[a];
    end
    i_rst_n          = 1'b0;
    bus.i_cmd_valid  = 1'b0;
    bus.i_cmd_write  = 1'b0;
    bus.i_cmd_sector = '0;
    bus.i_abort      = 1'b0;
    bus.i_wr_data    = '0;
    bus.i_wr_valid   = 1'b0;
    bus.i_rd_ready   = 1'b0;

    test_reset();
    test_write_sector();
    test_readback_ignore_cmd();
    test_read_stall();
    test_read_latency();
    test_timeout();
    test_abort_wait();
    test_reset_in_hold();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
